devre_tasarimi_mux_reg: RTL and testbench

Parameterised 2-operand, 4-function selector with registered output. An `opcode` picks one of four bitwise or arithmetic results computed from operands `C` and `D`, and the selected result is registered to `F`. It sits in the lab datapath as the operation-select stage between the operand sources and the result display/consumer logic.

---
 rtl/devre_tasarimi_mux_pkg.sv | 11 +
 rtl/devre_tasarimi_mux_reg_mux4.sv | 27 ++
 rtl/devre_tasarimi_mux_reg.sv | 58 +++++
 tb/tb_devre_tasarimi_mux_reg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/devre_tasarimi_mux_pkg.sv
// Shared opcode encoding for the operation-select stage.
package devre_tasarimi_mux_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

endpackage

// File: rtl/devre_tasarimi_mux_reg_mux4.sv
// Generic N-bit 4:1 combinational mux; select follows the opcode encoding.
module mux4
    import devre_tasarimi_mux_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic [N-1:0] i3,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);

    // Route the selected input to the output.
    always_comb begin
        y = i0;
        case (op_e'(sel))
            OP_AND:  y = i0;
            OP_OR:   y = i1;
            OP_XOR:  y = i2;
            OP_ADD:  y = i3;
            default: y = i0;
        endcase
    end

endmodule

// File: rtl/devre_tasarimi_mux_reg.sv
// Two-operand, four-function selector with a registered N-bit result.
module devre_tasarimi_mux_reg
    import devre_tasarimi_mux_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   opcode,
    output logic [N-1:0] F
);

    logic [N-1:0] and_res;
    logic [N-1:0] or_res;
    logic [N-1:0] xor_res;
    logic [N-1:0] add_res;
    logic [N-1:0] mux_y;
    logic [N-1:0] f_d;
    logic [N-1:0] f_q;
    op_e          op_sel;

    // All four candidate results in parallel; the add carry-out is dropped.
    assign and_res = C & D;
    assign or_res  = C | D;
    assign xor_res = C ^ D;
    assign add_res = N'(C + D);
    assign op_sel  = op_e'(opcode);

    mux4 #(
        .N (N)
    ) u_mux4 (
        .i0  (and_res),
        .i1  (or_res),
        .i2  (xor_res),
        .i3  (add_res),
        .sel (op_sel),
        .y   (mux_y)
    );

    // Next value of the result register is the selected function.
    always_comb begin
        f_d = mux_y;
    end

    // Result register; reset clears it immediately and wins over the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q <= '0;
        end else begin
            f_q <= f_d;
        end
    end

    assign F = f_q;

endmodule

// File: tb/tb_devre_tasarimi_mux_reg.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops one per edge.
module tb_devre_tasarimi_mux_reg;

    localparam int unsigned N = 2;

    typedef struct {
        string      name;
        logic [1:0] exp;
    } sb_entry_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] C;
    logic [N-1:0] D;
    logic [1:0]   opcode;
    logic [N-1:0] F;

    sb_entry_t sb_q[$];
    int        n_pass;
    int        n_total;

    devre_tasarimi_mux_reg #(
        .N (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .C      (C),
        .D      (D),
        .opcode (opcode),
        .F      (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [1:0] act, logic [1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: F=%b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // Independent reference: unsigned ops, sum reduced modulo 4.
    function automatic logic [1:0] ref_f(logic [1:0] op, logic [1:0] c, logic [1:0] d);
        int unsigned s;
        case (op)
            2'd0:    return c & d;
            2'd1:    return c | d;
            2'd2:    return c ^ d;
            default: begin
                s = (int'(c) + int'(d)) % 4;
                return 2'(s);
            end
        endcase
    endfunction

    task automatic push(string name, logic [1:0] exp);
        sb_entry_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Drive a vector between edges and expect its result after the next edge.
    task automatic drive(string name, logic [1:0] op, logic [1:0] c, logic [1:0] d,
                         logic [1:0] exp);
        @(negedge clk);
        opcode = op;
        C      = c;
        D      = d;
        push(name, exp);
    endtask

    // Monitor: F settles just after each rising edge; consume one expectation.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, F, e.exp);
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        C       = 2'b11;
        D       = 2'b11;
        opcode  = 2'b11;

        // Reset: clears F without a clock edge and holds across edges.
        #1 rst = 1'b1;
        #1 check("reset_async", F, 2'b00);
        push("reset_hold", 2'b00);
        repeat (2) begin
            @(negedge clk);
            push("reset_hold", 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;
        push("reset_release", 2'b10);

        // One vector per opcode.
        drive("op_and", 2'b00, 2'b00, 2'b11, 2'b00);
        drive("op_or",  2'b01, 2'b01, 2'b10, 2'b11);
        drive("op_xor", 2'b10, 2'b10, 2'b01, 2'b11);
        drive("op_add", 2'b11, 2'b11, 2'b00, 2'b11);

        // Addition wraps, carry dropped.
        drive("add_wrap_a", 2'b11, 2'b11, 2'b01, 2'b00);
        drive("add_wrap_b", 2'b11, 2'b10, 2'b10, 2'b00);

        // Mid-cycle input change has no effect until the next edge.
        drive("latency_first", 2'b01, 2'b01, 2'b10, 2'b11);
        @(posedge clk);
        #3;
        opcode = 2'b00;
        C      = 2'b00;
        D      = 2'b00;
        push("latency_update", 2'b00);
        #1 check("latency_hold", F, 2'b11);
        @(posedge clk);

        // Reset pulse between edges clears F; next edge reloads current selection.
        drive("pre_reset", 2'b11, 2'b11, 2'b00, 2'b11);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("mid_reset_async", F, 2'b00);
        #1 rst = 1'b0;
        #1 check("mid_reset_stays", F, 2'b00);
        push("mid_reset_reload", 2'b11);
        @(posedge clk);

        // Exhaustive back-to-back sweep against the reference model.
        for (int op = 0; op < 4; op++) begin
            for (int c = 0; c < 4; c++) begin
                for (int d = 0; d < 4; d++) begin
                    drive("exhaustive", 2'(op), 2'(c), 2'(d),
                          ref_f(2'(op), 2'(c), 2'(d)));
                end
            end
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expected results left, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
